// File: rtl/deser_lane_sched_pkg.sv
// Shared types and width helpers for the lane scheduler in front of the shared deserializer.
package deser_sched_pkg;

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    XFER_S  = 2'd1,
    WAIT_S  = 2'd2,
    ABORT_S = 2'd3
  } state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must hold the value n itself.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/deser_lane_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, cyclically.
module rr_arbiter
  import deser_sched_pkg::*;
#(
  parameter  int unsigned NUM_LANES = 4,
  localparam int unsigned LANE_W    = idx_w(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] req_i,
  input  logic [LANE_W-1:0]    ptr_i,
  output logic [NUM_LANES-1:0] gnt_o,
  output logic [LANE_W-1:0]    idx_o,
  output logic                 any_o
);

  int unsigned       cand;
  logic [LANE_W-1:0] cand_idx;
  logic              found;

  // Explicit wrap keeps the search correct for non-power-of-2 lane counts.
  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      cand = 32'(ptr_i) + i;
      if (cand >= NUM_LANES) cand = cand - NUM_LANES;
      cand_idx = LANE_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/deser_lane_sched.sv
// Round-robin scheduler sharing one serial-to-parallel deserializer among NUM_LANES serial lanes.
module deser_lane_sched
  import deser_sched_pkg::*;
#(
  parameter  int unsigned NUM_LANES      = 4,
  parameter  int unsigned DATA_BUS_WIDTH = 16,
  parameter  int unsigned DONE_TIMEOUT   = 8,
  localparam int unsigned LANE_W         = idx_w(NUM_LANES)
) (
  input  logic                      clk_i,
  input  logic                      srst_n_i,
  input  logic [NUM_LANES-1:0]      lane_req_i,
  output logic [NUM_LANES-1:0]      lane_gnt_o,
  input  logic [NUM_LANES-1:0]      lane_data_i,
  input  logic [NUM_LANES-1:0]      lane_data_val_i,
  output logic                      deser_srst_o,
  output logic                      deser_data_o,
  output logic                      deser_data_val_o,
  input  logic [DATA_BUS_WIDTH-1:0] deser_word_i,
  input  logic                      deser_word_val_i,
  output logic [DATA_BUS_WIDTH-1:0] word_o,
  output logic [LANE_W-1:0]         word_lane_o,
  output logic                      word_val_o,
  output logic                      timeout_o
);

  localparam int unsigned       BIT_W     = cnt_w(DATA_BUS_WIDTH);
  localparam int unsigned       TMO_W     = cnt_w(DONE_TIMEOUT);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BUS_WIDTH - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  state_e                    state_q;
  logic [LANE_W-1:0]         rr_ptr_q;
  logic [LANE_W-1:0]         sel_q;
  logic [NUM_LANES-1:0]      gnt_q;
  logic [BIT_W-1:0]          bit_cnt_q;
  logic [TMO_W-1:0]          wait_cnt_q;
  logic [DATA_BUS_WIDTH-1:0] word_q;
  logic [LANE_W-1:0]         word_lane_q;
  logic                      word_val_q;
  logic                      timeout_q;

  logic [NUM_LANES-1:0]      arb_gnt;
  logic [LANE_W-1:0]         arb_idx;
  logic                      arb_any;
  logic [LANE_W-1:0]         sel_next;
  logic                      xfer;
  logic                      bit_val;

  rr_arbiter #(.NUM_LANES(NUM_LANES)) u_arb (
    .req_i (lane_req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign sel_next = (sel_q == LAST_LANE) ? '0 : sel_q + LANE_W'(1);

  // Only the granted lane reaches the deserializer, and only while transferring.
  assign xfer             = (state_q == XFER_S);
  assign bit_val          = xfer & lane_data_val_i[sel_q];
  assign deser_data_val_o = bit_val;
  assign deser_data_o     = xfer & lane_data_i[sel_q];
  assign deser_srst_o     = ~srst_n_i | (state_q == ABORT_S);

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q     <= IDLE_S;
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      gnt_q       <= '0;
      bit_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      word_q      <= '0;
      word_lane_q <= '0;
      word_val_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      word_val_q <= 1'b0;
      timeout_q  <= 1'b0;
      unique case (state_q)
        IDLE_S: begin
          if (arb_any) begin
            sel_q     <= arb_idx;
            gnt_q     <= arb_gnt;
            bit_cnt_q <= '0;
            state_q   <= XFER_S;
          end
        end
        XFER_S: begin
          if (bit_val) begin
            if (bit_cnt_q == LAST_BIT) begin
              gnt_q      <= '0;
              bit_cnt_q  <= '0;
              wait_cnt_q <= TMO_W'(DONE_TIMEOUT);
              state_q    <= WAIT_S;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end
        end
        WAIT_S: begin
          if (deser_word_val_i) begin
            word_q      <= deser_word_i;
            word_lane_q <= sel_q;
            word_val_q  <= 1'b1;
            rr_ptr_q    <= sel_next;
            state_q     <= IDLE_S;
          end else if (wait_cnt_q <= TMO_W'(1)) begin
            // timeout_o is raised here so it lines up with the ABORT_S cycle.
            wait_cnt_q <= '0;
            timeout_q  <= 1'b1;
            state_q    <= ABORT_S;
          end else begin
            wait_cnt_q <= wait_cnt_q - TMO_W'(1);
          end
        end
        ABORT_S: begin
          rr_ptr_q <= sel_next;
          state_q  <= IDLE_S;
        end
        default: state_q <= IDLE_S;
      endcase
    end
  end

  assign lane_gnt_o  = gnt_q;
  assign word_o      = word_q;
  assign word_lane_o = word_lane_q;
  assign word_val_o  = word_val_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_deser_lane_sched.sv
// Scoreboard bench for deser_lane_sched with lane drivers and a behavioural deserializer.
module tb_deser_lane_sched;

  logic        clk;
  logic        srst_n;
  logic [3:0]  lane_req;
  logic [3:0]  lane_gnt;
  logic [3:0]  lane_data;
  logic [3:0]  lane_data_val;
  logic        deser_srst;
  logic        deser_data;
  logic        deser_data_val;
  logic [15:0] deser_word;
  logic        deser_word_val;
  logic [15:0] word;
  logic [1:0]  word_lane;
  logic        word_val;
  logic        timeout;

  logic        model_val;
  logic        stray_val;
  logic        stall;

  int          words_req  [4];
  int          words_done [4];
  int          lane_bit   [4];
  int          gap        [4];
  int          gap_cnt    [4];
  logic [15:0] lane_word  [4];
  logic [15:0] fixed_word [4];
  logic        fixed_en   [4];
  logic        noise_en   [4];
  logic        gnt_seen   [4];

  logic [17:0] sb_q[$];
  int          grant_log[$];
  int          n_pass, n_total;
  int          words_seen, timeouts, fwd_cnt, cyc, last_fwd;

  deser_lane_sched dut (
    .clk_i            (clk),
    .srst_n_i         (srst_n),
    .lane_req_i       (lane_req),
    .lane_gnt_o       (lane_gnt),
    .lane_data_i      (lane_data),
    .lane_data_val_i  (lane_data_val),
    .deser_srst_o     (deser_srst),
    .deser_data_o     (deser_data),
    .deser_data_val_o (deser_data_val),
    .deser_word_i     (deser_word),
    .deser_word_val_i (deser_word_val),
    .word_o           (word),
    .word_lane_o      (word_lane),
    .word_val_o       (word_val),
    .timeout_o        (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign deser_word_val = model_val | stray_val;

  always_comb begin
    for (int k = 0; k < 4; k++) lane_req[k] = (words_req[k] > words_done[k]);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_words(input int target);
    for (int i = 0; i < 800 && words_seen < target; i++) tick();
    check("wait_words", 32'(words_seen >= target), 1);
  endtask

  task automatic wait_fwd(input int target);
    for (int i = 0; i < 800 && fwd_cnt < target; i++) tick();
    check("wait_fwd", 32'(fwd_cnt >= target), 1);
  endtask

  // Lane front-ends: serialise MSB-first while granted, optional gaps and off-grant noise.
  initial begin
    lane_data = '0;
    lane_data_val = '0;
    for (int k = 0; k < 4; k++) begin
      words_done[k] = 0; lane_bit[k] = 16; gap_cnt[k] = 0;
      lane_word[k] = '0; gnt_seen[k] = 1'b0;
    end
    forever begin
      tick();
      for (int k = 0; k < 4; k++) begin
        if (lane_gnt[k] && !gnt_seen[k]) begin
          lane_word[k] = fixed_en[k] ? fixed_word[k] : 16'($urandom);
          lane_bit[k]  = 0;
          gap_cnt[k]   = 0;
        end
        gnt_seen[k] = lane_gnt[k];
        if (lane_gnt[k] && lane_bit[k] < 16) begin
          if (gap_cnt[k] == 0) begin
            lane_data[k]     = lane_word[k][15-lane_bit[k]];
            lane_data_val[k] = 1'b1;
            lane_bit[k]++;
            gap_cnt[k] = gap[k];
            if (lane_bit[k] == 16) begin
              if (!stall) sb_q.push_back({2'(k), lane_word[k]});
              words_done[k]++;
            end
          end else begin
            gap_cnt[k]--;
            lane_data[k]     = 1'($urandom);
            lane_data_val[k] = 1'b0;
          end
        end else begin
          lane_data[k]     = 1'($urandom);
          lane_data_val[k] = noise_en[k] ? 1'($urandom) : 1'b0;
        end
      end
    end
  end

  // Behavioural deserializer: shifts forwarded bits, returns the word after 0..3 cycles.
  initial begin
    logic [15:0] shreg, cap;
    int mcnt, mdly;
    bit mpend;
    model_val = 1'b0; deser_word = '0; shreg = '0; cap = '0;
    mcnt = 0; mdly = 0; mpend = 1'b0;
    forever begin
      @(negedge clk);
      model_val = 1'b0;
      if (deser_srst) begin
        mcnt = 0; mpend = 1'b0;
      end else begin
        if (mpend) begin
          if (mdly == 0) begin
            deser_word = cap; model_val = 1'b1; mpend = 1'b0;
          end else mdly--;
        end
        if (deser_data_val) begin
          shreg = {shreg[14:0], deser_data};
          mcnt++;
          if (mcnt == 16) begin
            mcnt = 0; cap = shreg;
            if (!stall) begin mpend = 1'b1; mdly = $urandom_range(0, 3); end
          end
        end
      end
    end
  end

  // Output monitor: mux isolation, grant order, scoreboard pops, timeout pulses.
  initial begin
    logic [17:0] exp;
    logic [3:0]  gprev;
    logic        wv_prev, to_prev;
    gprev = '0; wv_prev = 1'b0; to_prev = 1'b0;
    cyc = 0; last_fwd = 0; fwd_cnt = 0; words_seen = 0; timeouts = 0;
    forever begin
      @(negedge clk);
      cyc++;
      check("mux_val", 32'(deser_data_val), 32'(|(lane_gnt & lane_data_val)));
      if (deser_data_val) begin
        fwd_cnt++;
        last_fwd = cyc;
        check("mux_bit", 32'(deser_data), 32'(|(lane_gnt & lane_data)));
      end
      if ($countones(lane_gnt) > 1) check("gnt_onehot", 32'(lane_gnt), 0);
      for (int k = 0; k < 4; k++) if (lane_gnt[k] && !gprev[k]) grant_log.push_back(k);
      gprev = lane_gnt;
      if (word_val) begin
        words_seen++;
        check("wv_pulse", 32'(wv_prev), 0);
        if (sb_q.size() == 0) check("spurious_word", 32'(word), 0);
        else begin
          exp = sb_q.pop_front();
          check("word", 32'(word), 32'(exp[15:0]));
          check("word_lane", 32'(word_lane), 32'(exp[17:16]));
        end
      end
      if (timeout) begin
        timeouts++;
        check("to_pulse", 32'(to_prev), 0);
        check("to_srst", 32'(deser_srst), 1);
        check("to_no_word", 32'(word_val), 0);
        check("to_latency", 32'(cyc - last_fwd), 9);
      end
      wv_prev = word_val;
      to_prev = timeout;
    end
  end

  initial begin
    int gl, w0, f0, t0;
    int exp_order[5];
    n_pass = 0; n_total = 0;
    srst_n = 1'b0; stray_val = 1'b0; stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      words_req[k] = 0; gap[k] = 0; fixed_word[k] = '0; fixed_en[k] = 1'b0; noise_en[k] = 1'b0;
    end
    repeat (3) tick();
    check("rst_gnt", 32'(lane_gnt), 0);
    check("rst_word", 32'(word), 0);
    check("rst_lane", 32'(word_lane), 0);
    check("rst_wv", 32'(word_val), 0);
    check("rst_to", 32'(timeout), 0);
    check("rst_dsrst", 32'(deser_srst), 1);
    check("rst_dval", 32'(deser_data_val), 0);
    srst_n = 1'b1;
    tick();
    check("rel_dsrst", 32'(deser_srst), 0);

    // Single lane 2, fixed word, then rr_ptr must sit at 3.
    fixed_word[2] = 16'hA5C3; fixed_en[2] = 1'b1;
    words_req[2] += 1;
    wait_words(1);
    fixed_en[2] = 1'b0;
    check("t1_word_hold", 32'(word), 32'h0000_A5C3);
    check("t1_lane_hold", 32'(word_lane), 2);
    gl = grant_log.size();
    words_req[0] += 1; words_req[3] += 1;
    wait_words(3);
    check("t1_rrptr3", 32'(grant_log[gl]), 3);
    check("t1_then0", 32'(grant_log[gl+1]), 0);

    // All lanes requesting from rr_ptr=0.
    srst_n = 1'b0; tick(); srst_n = 1'b1; tick();
    gl = grant_log.size(); w0 = words_seen;
    words_req[0] += 2; words_req[1] += 1; words_req[2] += 1; words_req[3] += 1;
    wait_words(w0 + 5);
    exp_order = '{0, 1, 2, 3, 0};
    check("t2_log_len", 32'(grant_log.size() - gl), 5);
    for (int i = 0; i < 5; i++) check("t2_order", 32'(grant_log[gl+i]), 32'(exp_order[i]));

    // Lane 1 with a bit every third cycle while lane 3 toggles its valid.
    gap[1] = 2; noise_en[3] = 1'b1;
    f0 = fwd_cnt; w0 = words_seen;
    words_req[1] += 1;
    wait_words(w0 + 1);
    check("t3_fwd16", 32'(fwd_cnt - f0), 16);
    gap[1] = 0; noise_en[3] = 1'b0;

    // Deserializer stall on lane 2: timeout, no word, next grant to lane 3.
    stall = 1'b1; t0 = timeouts; w0 = words_seen;
    words_req[2] += 1;
    for (int i = 0; i < 300 && timeouts == t0; i++) tick();
    check("t4_timeout", 32'(timeouts - t0), 1);
    repeat (2) tick();
    stall = 1'b0;
    check("t4_no_word", 32'(words_seen), 32'(w0));
    gl = grant_log.size();
    words_req[2] += 1; words_req[3] += 1;
    wait_words(w0 + 2);
    check("t4_next3", 32'(grant_log[gl]), 3);
    check("t4_then2", 32'(grant_log[gl+1]), 2);

    // Reset around bit 7 of a lane 1 transfer.
    f0 = fwd_cnt; w0 = words_seen;
    words_req[1] += 1;
    wait_fwd(f0 + 7);
    srst_n = 1'b0;
    @(negedge clk);
    check("t5_dsrst_low", 32'(deser_srst), 1);
    tick();
    check("t5_gnt", 32'(lane_gnt), 0);
    check("t5_word", 32'(word), 0);
    check("t5_lane", 32'(word_lane), 0);
    check("t5_wv", 32'(word_val), 0);
    check("t5_to", 32'(timeout), 0);
    check("t5_dval", 32'(deser_data_val), 0);
    srst_n = 1'b1;
    words_req[1] = words_done[1];
    repeat (4) tick();
    check("t5_no_word", 32'(words_seen), 32'(w0));
    check("t5_sb_empty", 32'(sb_q.size()), 0);
    gl = grant_log.size();
    words_req[0] += 1; words_req[3] += 1;
    wait_words(w0 + 2);
    check("t5_ptr0", 32'(grant_log[gl]), 0);

    // Stray word-valid in IDLE_S and in XFER_S.
    w0 = words_seen;
    stray_val = 1'b1; tick(); stray_val = 1'b0;
    repeat (3) tick();
    check("t6_idle_gnt", 32'(lane_gnt), 0);
    check("t6_idle_nowv", 32'(words_seen), 32'(w0));
    f0 = fwd_cnt;
    words_req[1] += 1;
    wait_fwd(f0 + 5);
    stray_val = 1'b1; tick(); stray_val = 1'b0;
    check("t6_xfer_gnt", 32'(lane_gnt), 32'h2);
    wait_words(w0 + 1);
    check("t6_fwd16", 32'(fwd_cnt - f0), 16);
    repeat (10) tick();
    check("t6_one_word", 32'(words_seen), 32'(w0 + 1));
    check("sb_empty", 32'(sb_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/deser_lane_sched.md
Name: deser_lane_sched

Overview:
- Round-robin scheduler that shares one serial-to-parallel deserializer among NUM_LANES serial sources.
- Grants one lane at a time and forwards exactly DATA_BUS_WIDTH valid bits from that lane into the deserializer.
- Waits for the parallel word, tags it with the lane index, then rotates priority.
- Sits between the lane front-ends and the shared deserializer instance.

Parameters:
- NUM_LANES, 4, number of serial requesters (2..16).
- DATA_BUS_WIDTH, 16, bits per word; must equal the deserializer's width.
- DONE_TIMEOUT, 8, maximum cycles to wait for the deserializer's word-valid after the last bit.

Ports:
- clk_i  in  1  single clock.
- srst_n_i  in  1  reset, synchronous and active-low.
- lane_req_i  in  NUM_LANES  per-lane request: lane has a word to send.
- lane_gnt_o  out  NUM_LANES  one-hot grant, registered.
- lane_data_i  in  NUM_LANES  per-lane serial bit.
- lane_data_val_i  in  NUM_LANES  per-lane bit-valid.
- deser_srst_o  out  1  active-high synchronous reset to the deserializer.
- deser_data_o  out  1  muxed serial bit to the deserializer.
- deser_data_val_o  out  1  muxed bit-valid to the deserializer.
- deser_word_i  in  DATA_BUS_WIDTH  parallel word from the deserializer.
- deser_word_val_i  in  1  word-valid from the deserializer.
- word_o  out  DATA_BUS_WIDTH  captured word.
- word_lane_o  out  $clog2(NUM_LANES)  source lane of word_o.
- word_val_o  out  1  one-cycle pulse qualifying word_o and word_lane_o.
- timeout_o  out  1  one-cycle pulse: deserializer failed to return a word.

Behaviour:
- Reset (srst_n_i=0 at a clock edge):
  - state=IDLE_S, rr_ptr=0, bit_cnt=0.
  - lane_gnt_o=0, word_o=0, word_lane_o=0, word_val_o=0, timeout_o=0.
  - deser_srst_o=1 while srst_n_i=0 (combinational from srst_n_i or the abort pulse).
- Reset mid-operation aborts any transfer and clears all state; no word is emitted.
- States: IDLE_S, XFER_S, WAIT_S, ABORT_S. Defined in a shared package.
- IDLE_S:
  - If any lane_req_i bit is set, select the first requesting lane at or after rr_ptr, cyclically.
  - Next cycle: state=XFER_S, lane_gnt_o one-hot on the selected lane, bit_cnt=0.
  - With no request, stay in IDLE_S and hold lane_gnt_o=0.
- XFER_S:
  - deser_data_o = lane_data_i[sel], deser_data_val_o = lane_data_val_i[sel], zero-latency combinational mux.
  - In every other state both outputs are 0; lane_data_val_i of ungranted lanes never propagates.
  - bit_cnt increments on each forwarded valid. Gaps (valid=0) are allowed and hold the count.
  - On the valid with bit_cnt==DATA_BUS_WIDTH-1: next state=WAIT_S, lane_gnt_o=0, and the wait counter is loaded with DONE_TIMEOUT.
  - Deassertion of lane_req_i during XFER_S is ignored; the grant is held until the word completes.
- WAIT_S:
  - On deser_word_val_i: register word_o=deser_word_i and word_lane_o=sel, pulse word_val_o next cycle, set rr_ptr=(sel+1) mod NUM_LANES, go to IDLE_S.
  - The earliest next grant is one cycle after the word_val_o pulse, so back-to-back words from different lanes are separated by 2 idle cycles minimum.
  - Otherwise decrement the wait counter. At 0: go to ABORT_S.
- ABORT_S (1 cycle):
  - deser_srst_o=1, timeout_o=1, rr_ptr advances past sel, no word_val_o, then IDLE_S.
- deser_word_val_i outside WAIT_S is ignored; no output results.
- word_o and word_lane_o hold their last value between pulses.
- Arithmetic: rr_ptr and sel are $clog2(NUM_LANES) bits with explicit modulo wrap for non-power-of-2 NUM_LANES. bit_cnt is $clog2(DATA_BUS_WIDTH+1) bits.

Decomposition:
- Package deser_sched_pkg: state enum (IDLE_S, XFER_S, WAIT_S, ABORT_S) and width helper functions for lane index and count.
- Sub-module rr_arbiter: combinational round-robin pick with inputs req and ptr, outputs one-hot gnt and index.
- The parent holds the FSM, counters, mux and output registers.

Test Plan:
- Single lane: lane 2 requests, sends 16 bits 0xA5C3 MSB-first with no gaps, deserializer returns 0xA5C3 -> word_val_o=1 for one cycle, word_o=0xA5C3, word_lane_o=2, rr_ptr=3.
- All four lanes request continuously -> grants issued in order 0,1,2,3,0 and each word_lane_o matches its granted lane.
- Lane 1 granted with valid gaps (bit every 3rd cycle) while lane 3 toggles lane_data_val_i -> exactly 16 valids forwarded, all from lane 1, and lane 3 traffic never appears on deser_data_val_o.
- Deserializer stalls with no word_val within 8 cycles after the 16th bit -> one-cycle timeout_o and deser_srst_o pulse, no word_val_o, next grant goes to the following lane.
- srst_n_i low for 1 cycle at bit 7 of a transfer -> all outputs 0, deser_srst_o=1 during reset, FSM in IDLE_S, rr_ptr=0, no word emitted.
- Stray deser_word_val_i asserted in IDLE_S and XFER_S -> no word_val_o and no state change.
